// File: rtl/mac_controller.sv
// rtl/mac_controller.sv - sequencer for the 4-bit MAC datapath N-term dot product
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           job request, honoured only in IDLE
//   abort           synchronous abort, highest priority in every state
//   op_valid        operand source presents A/B on the datapath inputs
//   op_ready        controller takes the operand pair this cycle
//   dp_done         datapath done flag, awaited after the output load
//   dp_cmp          datapath count-compare flag, monitor only
//   load_a..load_out, count_enable
//                   datapath strobes, at most one group per cycle
//   busy            job in progress (low only in IDLE)
//   done            one-cycle job-complete pulse
//   err             sticky error: done timeout or mid-job abort
//   term_cnt        terms accumulated in the current job

module mac_controller #(
  parameter int N_TERMS      = 10,
  parameter int CNT_W        = 4,
  parameter int DONE_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             dp_done,
  input  logic             dp_cmp,
  output logic             load_a,
  output logic             load_b,
  output logic             load_m,
  output logic             load_acc,
  output logic             load_out,
  output logic             count_enable,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] term_cnt
);

  localparam int TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_MUL       = 3'd2,
    S_ACC       = 3'd3,
    S_OUT       = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  term_cnt_r;
  logic              err_r;
  logic [TO_W-1:0]   wait_cnt;
  logic              last_term;
  logic              timeout_hit;
  logic              job_accept;
  logic              mid_job;

  // dp_cmp is a monitor-only flag; sequencing never depends on it.
  logic              unused_dp_cmp;
  assign unused_dp_cmp = dp_cmp;

  assign last_term   = (term_cnt_r + 1'b1) == CNT_W'(N_TERMS);
  // wait_cnt counts cycles already spent in WAIT_DONE, so the last allowed
  // cycle is the one where it equals DONE_TIMEOUT-1.
  assign timeout_hit = (wait_cnt == TO_W'(DONE_TIMEOUT - 1));
  assign job_accept  = (state == S_IDLE) && start && !abort;
  // States in which an abort counts as an interrupted job.
  assign mid_job     = (state == S_FETCH) || (state == S_MUL) || (state == S_ACC) ||
                       (state == S_OUT)   || (state == S_WAIT_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start) state_nxt = S_FETCH;
        S_FETCH:     if (op_valid) state_nxt = S_MUL;
        S_MUL:       state_nxt = S_ACC;
        S_ACC:       state_nxt = last_term ? S_OUT : S_FETCH;
        S_OUT:       state_nxt = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (dp_done) begin
            state_nxt = S_DONE;
          end else if (timeout_hit) begin
            state_nxt = S_IDLE;
          end
        end
        S_DONE:      state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Term counter, done-wait timer and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_cnt_r <= '0;
      err_r      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (job_accept) begin
        term_cnt_r <= '0;
        err_r      <= 1'b0;
      end

      // The datapath accumulates whenever ACC is entered, abort or not, so
      // the count follows it to stay consistent with the accumulator.
      if (state == S_ACC) begin
        term_cnt_r <= term_cnt_r + 1'b1;
      end

      if (state == S_WAIT_DONE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (abort && mid_job) begin
        err_r <= 1'b1;
      end else if ((state == S_WAIT_DONE) && !dp_done && timeout_hit) begin
        err_r <= 1'b1;
      end
    end
  end

  // Outputs. Only the operand handshake looks at inputs; every other strobe
  // is a pure decode of the state register.
  always_comb begin
    op_ready     = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_m       = 1'b0;
    load_acc     = 1'b0;
    load_out     = 1'b0;
    count_enable = 1'b0;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    case (state)
      S_FETCH: begin
        // An abort in FETCH must not accept or load the presented pair.
        op_ready = !abort;
        load_a   = op_valid && !abort;
        load_b   = op_valid && !abort;
      end
      S_MUL:   load_m = 1'b1;
      S_ACC: begin
        load_acc     = 1'b1;
        count_enable = 1'b1;
      end
      S_OUT:   load_out = 1'b1;
      default: ;
    endcase
  end

  assign err      = err_r;
  assign term_cnt = term_cnt_r;

endmodule

// File: tb/tb_mac_controller.sv
// tb/tb_mac_controller.sv - self-checking bench for mac_controller

module tb_mac_controller;

  localparam int N  = 10;
  localparam int CW = 4;
  localparam int TO = 4;

  // Bit positions inside the packed expected-output word.
  localparam int B_RDY  = 9;
  localparam int B_LA   = 8;
  localparam int B_LB   = 7;
  localparam int B_LM   = 6;
  localparam int B_LACC = 5;
  localparam int B_LOUT = 4;
  localparam int B_CE   = 3;
  localparam int B_BUSY = 2;
  localparam int B_DONE = 1;
  localparam int B_ERR  = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          dp_done;
  logic          dp_cmp;
  logic          load_a, load_b, load_m, load_acc, load_out, count_enable;
  logic          busy, done, err;
  logic [CW-1:0] term_cnt;

  always #5 clk = ~clk;

  mac_controller #(.N_TERMS(N), .CNT_W(CW), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready),
    .dp_done(dp_done), .dp_cmp(dp_cmp),
    .load_a(load_a), .load_b(load_b), .load_m(load_m), .load_acc(load_acc),
    .load_out(load_out), .count_enable(count_enable),
    .busy(busy), .done(done), .err(err), .term_cnt(term_cnt)
  );

  // Small datapath stand-in driven by the controller strobes.
  logic [3:0]  op_a = 4'd0;
  logic [3:0]  op_b = 4'd0;
  logic [3:0]  ra, rb;
  logic [7:0]  rm;
  logic [15:0] racc, rout;
  logic [7:0]  dp_cnt;
  logic        dp_en = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0; rb <= '0; rm <= '0; racc <= '0; rout <= '0;
      dp_cnt <= '0; dp_done <= 1'b0;
    end else begin
      if (load_a) ra <= op_a;
      if (load_b) rb <= op_b;
      if (load_m) rm <= 8'(ra) * 8'(rb);
      if (load_acc) racc <= racc + 16'(rm);
      if (load_out) rout <= racc;
      if (count_enable) dp_cnt <= dp_cnt + 8'd1;
      dp_done <= load_out && dp_en;
    end
  end
  assign dp_cmp = (dp_cnt == 8'(N));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected per-cycle trace: inputs to apply and outputs they must produce.
  typedef struct packed {
    logic       start;
    logic       abort;
    logic       op_valid;
    logic [9:0] outs;
    logic [7:0] tc;
  } vec_t;

  typedef enum int {PH_START, PH_STALL, PH_FETCH, PH_MUL, PH_ACC, PH_OUT, PH_WAIT, PH_DONE} ph_t;

  vec_t q[$];
  int   m_tc = 0;
  bit   m_err = 1'b0;
  int   cyc, m_abort_at, m_cut;
  bit   stopped, m_noise;

  // Append one cycle of a job to the trace, then apply its effect on the
  // job-level bookkeeping (term count, sticky error).
  task automatic step(input ph_t ph, input bit ov);
    vec_t v;
    if (stopped) return;
    if (cyc >= m_cut) begin
      stopped = 1'b1;
      return;
    end
    v = '0;
    v.start        = (ph == PH_START) ? 1'b1 : m_noise;
    v.abort        = (cyc == m_abort_at);
    v.op_valid     = ov;
    v.outs[B_BUSY] = (ph != PH_START);
    v.outs[B_ERR]  = m_err;
    v.tc           = 8'(m_tc);
    case (ph)
      PH_STALL: v.outs[B_RDY] = 1'b1;
      PH_FETCH: if (!v.abort) begin
        v.outs[B_RDY] = 1'b1; v.outs[B_LA] = 1'b1; v.outs[B_LB] = 1'b1;
      end
      PH_MUL:   v.outs[B_LM] = 1'b1;
      PH_ACC:   begin v.outs[B_LACC] = 1'b1; v.outs[B_CE] = 1'b1; end
      PH_OUT:   v.outs[B_LOUT] = 1'b1;
      PH_DONE:  v.outs[B_DONE] = 1'b1;
      default:  ;
    endcase
    q.push_back(v);
    if (ph == PH_ACC) m_tc++;
    if (v.abort) begin
      stopped = 1'b1;
      if (ph != PH_START && ph != PH_DONE) m_err = 1'b1;
    end else if (ph == PH_START) begin
      m_err = 1'b0;
      m_tc  = 0;
    end
    cyc++;
  endtask

  task automatic gen_job(input int stall_term, input int stall_len, input bit done_ok,
                         input int abort_at, input bit noise, input int cut);
    cyc = 0; stopped = 1'b0; m_abort_at = abort_at; m_noise = noise; m_cut = cut;
    step(PH_START, 1'b1);
    for (int k = 1; k <= N; k++) begin
      if (k == stall_term) begin
        for (int s = 0; s < stall_len; s++) step(PH_STALL, 1'b0);
      end
      step(PH_FETCH, 1'b1);
      step(PH_MUL, 1'b1);
      step(PH_ACC, 1'b1);
    end
    step(PH_OUT, 1'b1);
    if (done_ok) begin
      step(PH_WAIT, 1'b1);
      step(PH_DONE, 1'b1);
    end else begin
      for (int t = 0; t < TO; t++) step(PH_WAIT, 1'b1);
      if (!stopped) m_err = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = '0;
      v.outs[B_ERR] = m_err;
      v.tc = 8'(m_tc);
      q.push_back(v);
    end
  endtask

  int n_la, n_lm, n_acc, n_out, n_done, done_idx;

  function automatic logic [9:0] dut_outs();
    return {op_ready, load_a, load_b, load_m, load_acc, load_out, count_enable, busy, done, err};
  endfunction

  // Drive the trace and compare every cycle.
  task automatic run_q();
    logic [9:0] act;
    int groups;
    n_la = 0; n_lm = 0; n_acc = 0; n_out = 0; n_done = 0; done_idx = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      start    = q[i].start;
      abort    = q[i].abort;
      op_valid = q[i].op_valid;
      @(negedge clk);
      act = dut_outs();
      chk($sformatf("outs[%0d]", i), int'(act), int'(q[i].outs));
      chk($sformatf("term_cnt[%0d]", i), int'(term_cnt), int'(q[i].tc));
      groups = int'(load_a | load_b) + int'(load_m) + int'(load_acc | count_enable) + int'(load_out);
      chk($sformatf("onehot[%0d]", i), int'(groups <= 1), 1);
      if (load_a) n_la++;
      if (load_m) n_lm++;
      if (load_acc) n_acc++;
      if (load_out) n_out++;
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
    end
    q.delete();
    start = 1'b0; abort = 1'b0; op_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_tc = 0; m_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", int'(dut_outs()), 0);
    chk("reset_term_cnt", int'(term_cnt), 0);
    rst = 1'b0;

    // Plain job, A=3, B=4.
    op_a = 4'd3; op_b = 4'd4; dp_en = 1'b1;
    gen_job(0, 0, 1'b1, -1, 1'b0, 1000); idle(2); run_q();
    chk("j1_load_a", n_la, 10);
    chk("j1_load_m", n_lm, 10);
    chk("j1_load_acc", n_acc, 10);
    chk("j1_load_out", n_out, 1);
    chk("j1_done_cycle", done_idx, 33);
    chk("j1_term_cnt", int'(term_cnt), 10);
    chk("j1_dp_out", int'(rout), 120);

    // Five-cycle stall before term 4, A=B=15.
    pulse_rst();
    op_a = 4'd15; op_b = 4'd15;
    gen_job(4, 5, 1'b1, -1, 1'b0, 1000); idle(2); run_q();
    chk("j2_done_cycle", done_idx, 38);
    chk("j2_dp_out", int'(rout), 2250);

    // Done never arrives: timeout error, then err persists until a start.
    dp_en = 1'b0;
    gen_job(0, 0, 1'b0, -1, 1'b0, 1000); idle(3); run_q();
    chk("to_err", int'(err), 1);
    chk("to_no_done", n_done, 0);
    dp_en = 1'b1;
    gen_job(0, 0, 1'b1, 0, 1'b0, 1000); idle(1); run_q();
    chk("start_abort_err_held", int'(err), 1);
    chk("start_abort_busy", int'(busy), 0);
    gen_job(0, 0, 1'b1, -1, 1'b0, 1000); idle(2); run_q();
    chk("after_to_done_cycle", done_idx, 33);
    chk("after_to_err", int'(err), 0);

    // Abort in MUL of term 6, in FETCH with op_valid, and in DONE.
    gen_job(0, 0, 1'b1, 17, 1'b0, 1000); idle(2); run_q();
    chk("abort_mul_term_cnt", int'(term_cnt), 5);
    chk("abort_mul_err", int'(err), 1);
    chk("abort_mul_busy", int'(busy), 0);
    gen_job(0, 0, 1'b1, 4, 1'b0, 1000); idle(2); run_q();
    chk("abort_fetch_load_a", n_la, 1);
    chk("abort_fetch_term_cnt", int'(term_cnt), 1);
    gen_job(0, 0, 1'b1, 33, 1'b0, 1000); idle(2); run_q();
    chk("abort_done_err", int'(err), 0);
    chk("abort_done_pulses", n_done, 1);

    // start held high for the whole job.
    gen_job(0, 0, 1'b1, -1, 1'b1, 1000); idle(2); run_q();
    chk("noise_done_pulses", n_done, 1);
    chk("noise_done_cycle", done_idx, 33);

    // Asynchronous reset in the middle of ACC, then a full job.
    gen_job(0, 0, 1'b1, -1, 1'b0, 7); run_q();
    chk("pre_rst_load_acc", int'(load_acc), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", int'(dut_outs()), 0);
    chk("async_rst_term_cnt", int'(term_cnt), 0);
    @(negedge clk); rst = 1'b0;
    m_tc = 0; m_err = 1'b0;
    gen_job(0, 0, 1'b1, -1, 1'b0, 1000); idle(2); run_q();
    chk("post_rst_done_cycle", done_idx, 33);
    chk("post_rst_term_cnt", int'(term_cnt), 10);
    chk("post_rst_dp_out", int'(rout), 2250);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_controller.md
Name: mac_controller

Overview:
FSM controller that sequences the 4-bit MAC datapath through an N-term multiply-accumulate dot product. It accepts a start command and fetches one operand pair per term over a valid/ready handshake. It drives the datapath's one-hot load strobes, counts terms internally and confirms completion against the datapath done flag. It sits between the requesting logic (operand source or host) and the MAC datapath.

Parameters:
N_TERMS, 10, number of A*B products accumulated per job (1..15)
CNT_W, 4, width of term counter and term_cnt output (must hold N_TERMS)
DONE_TIMEOUT, 4, max cycles spent in WAIT_DONE before flagging an error (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  job request, sampled in IDLE only
abort  in  1  synchronous abort, any state
op_valid  in  1  operand source has A/B valid on the datapath inputs
op_ready  out  1  controller accepts an operand pair this cycle
dp_done  in  1  datapath done flag
dp_cmp  in  1  datapath count-compare flag, monitor only, never gates the FSM
load_a  out  1  datapath strobe, load A
load_b  out  1  datapath strobe, load B
load_m  out  1  datapath strobe, product register
load_acc  out  1  datapath strobe, accumulate
load_out  out  1  datapath strobe, output register
count_enable  out  1  datapath counter advance
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse
err  out  1  sticky error: done timeout or abort mid-job
term_cnt  out  CNT_W  terms accumulated in the current job

Behaviour:
- Reset (async): state=IDLE, term_cnt=0, err=0. All strobes, op_ready, busy and done are 0.
- States: IDLE, FETCH, MUL, ACC, OUT, WAIT_DONE, DONE.
- IDLE:
  - start=1 -> FETCH, term_cnt<=0, err<=0.
  - busy=0 only in IDLE.
- FETCH:
  - op_ready=1.
  - load_a=load_b=op_valid (combinational).
  - op_valid=1 -> MUL. Otherwise stay; stalling is unlimited.
- MUL: load_m=1 -> ACC.
- ACC:
  - load_acc=1, count_enable=1, term_cnt<=term_cnt+1.
  - Then: if term_cnt+1==N_TERMS -> OUT, else -> FETCH.
- OUT: load_out=1 -> WAIT_DONE.
- WAIT_DONE:
  - dp_done=1 -> DONE.
  - Timeout counter runs from entry. If it reaches DONE_TIMEOUT cycles without dp_done: err<=1 -> IDLE, no done pulse.
- DONE: done=1 for exactly one cycle -> IDLE.
- Strobe rules:
  - At most one strobe group is active per cycle: {load_a,load_b}, load_m, load_acc+count_enable, load_out. The datapath uses a priority chain, so overlap corrupts it.
  - Strobes other than load_a/load_b decode from the state register only; they are glitch-free Moore outputs.
- Latency:
  - Per term, 3 cycles minimum (FETCH with op_valid, MUL, ACC). Each idle-valid cycle in FETCH adds 1.
  - With op_valid held high: start sampled at cycle 0 -> done pulse at cycle 3*N_TERMS+3. For N=10, that is cycle 33.
- Abort:
  - abort=1 in any non-IDLE state -> IDLE next cycle. All strobes are 0 in that next cycle; term_cnt holds its value.
  - err<=1 if abort occurs in FETCH..WAIT_DONE. Abort in IDLE or DONE does not set err.
  - abort has priority over every other transition, including op_valid and dp_done in the same cycle.
- start while busy: ignored, no queueing.
- start and abort together in IDLE: abort wins, stay IDLE.
- term_cnt never exceeds N_TERMS. It holds its value after the job and clears on the next accepted start.
- The datapath accumulator clears only on rst. Back-to-back jobs therefore accumulate on top of the prior result; the system applies rst between jobs where a fresh sum is needed.
- Reset mid-job: immediate return to IDLE, all outputs at reset values.

Test Plan:
- Reset, then start=1 for 1 cycle, op_valid held 1, A=3, B=4, N=10 -> 10 load_a/b strobes, 10 load_m, 10 load_acc, term_cnt=10, one load_out. Datapath out=120, done pulse at cycle 33 after start, busy low the next cycle.
- op_valid low for 5 cycles before term 4 (A=15, B=15, all terms) -> FETCH stalls 5 cycles with op_ready=1 and no strobes. Done at cycle 38. Datapath out=2250 (10*225).
- Tie dp_done=0 -> after load_out, WAIT_DONE for 4 cycles, then err=1 and return to IDLE with no done pulse. err stays 1 until the next start.
- abort asserted in MUL of term 6 -> next cycle state IDLE, all strobes 0, term_cnt=5, err=1, busy=0. abort asserted together with op_valid in FETCH -> no load_a/b strobe.
- start pulsed repeatedly during a job -> ignored; exactly one done pulse per job. Strobe one-hot check asserted every cycle.
- rst asserted asynchronously mid-ACC -> outputs immediately at reset values. A subsequent start runs a full 33-cycle job correctly.
